mips_mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS datapath. It consumes the fetched instruction word and the ALU zero flag from the datapath and drives every datapath control input. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states so that register-file, data-memory and PC writes occur in exactly one cycle per instruction. It sits beside the datapath at the CPU top level.

---
 rtl/mips_mc_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Multi-cycle MIPS control unit. Sequences FETCH/DECODE/EXEC/
//               MEM/WB and drives datapath steering and strobe controls.
//               Optional lui support is enabled by defining MIPS_CTRL_LUI_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instructionOP,
    input  logic        zero,
    output logic        RegDst,
    output logic        RegWr,
    output logic [1:0]  ExtOp,
    output logic [1:0]  ALUctr,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        MemWr,
    output logic [1:0]  nPC_sel,
    output logic        j_sel,
    output logic [25:0] jValue,
    output logic        pc_en,
    output logic        instr_done,
    output logic        illegal
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;

    localparam logic [1:0] c_EXT_ZERO = 2'b00;
    localparam logic [1:0] c_EXT_SIGN = 2'b01;
    localparam logic [1:0] c_EXT_LUI  = 2'b10;
    localparam logic [1:0] c_ALU_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_SUB  = 2'b01;
    localparam logic [1:0] c_ALU_OR   = 2'b10;

    typedef enum logic [2:0] {
        c_ST_FETCH  = 3'd0,
        c_ST_DECODE = 3'd1,
        c_ST_EXEC   = 3'd2,
        c_ST_MEM    = 3'd3,
        c_ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        c_CL_ILL  = 4'd0,
        c_CL_ADDU = 4'd1,
        c_CL_SUBU = 4'd2,
        c_CL_ORI  = 4'd3,
        c_CL_LW   = 4'd4,
        c_CL_SW   = 4'd5,
        c_CL_BEQ  = 4'd6,
        c_CL_J    = 4'd7,
        c_CL_LUI  = 4'd8
    } iclass_t;

    state_t      r_state;
    logic [31:0] r_ir;
    iclass_t     w_class;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_final;

    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];

    // Instruction classification; everything not listed decodes as illegal.
    always_comb begin
        w_class = c_CL_ILL;
        case (w_op)
            c_OP_RTYPE: begin
                if (w_funct == c_FN_ADDU)
                    w_class = c_CL_ADDU;
                else if (w_funct == c_FN_SUBU)
                    w_class = c_CL_SUBU;
            end
            c_OP_ORI: w_class = c_CL_ORI;
            c_OP_LW:  w_class = c_CL_LW;
            c_OP_SW:  w_class = c_CL_SW;
            c_OP_BEQ: w_class = c_CL_BEQ;
            c_OP_J:   w_class = c_CL_J;
`ifdef MIPS_CTRL_LUI_EN
            c_OP_LUI: w_class = c_CL_LUI;
`else
            c_OP_LUI: w_class = c_CL_ILL;
`endif
            default:  w_class = c_CL_ILL;
        endcase
    end

    always_comb begin
        w_final = 1'b0;
        case (r_state)
            c_ST_DECODE: w_final = (w_class == c_CL_ILL) || (w_class == c_CL_J);
            c_ST_EXEC:   w_final = (w_class == c_CL_BEQ);
            c_ST_MEM:    w_final = (w_class == c_CL_SW);
            c_ST_WB:     w_final = 1'b1;
            default:     w_final = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_FETCH;
            r_ir    <= 32'd0;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    r_ir    <= instructionOP;
                    r_state <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    if (w_final)
                        r_state <= c_ST_FETCH;
                    else
                        r_state <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    if (w_class == c_CL_BEQ)
                        r_state <= c_ST_FETCH;
                    else if ((w_class == c_CL_LW) || (w_class == c_CL_SW))
                        r_state <= c_ST_MEM;
                    else
                        r_state <= c_ST_WB;
                end
                c_ST_MEM: begin
                    if (w_class == c_CL_LW)
                        r_state <= c_ST_WB;
                    else
                        r_state <= c_ST_FETCH;
                end
                default: r_state <= c_ST_FETCH;
            endcase
        end
    end

    // Steering is held from DECODE through the final state; zero in FETCH.
    always_comb begin
        RegDst   = 1'b0;
        ExtOp    = c_EXT_ZERO;
        ALUctr   = c_ALU_ADD;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        if (r_state != c_ST_FETCH) begin
            case (w_class)
                c_CL_ADDU: begin
                    RegDst = 1'b1;
                    ALUctr = c_ALU_ADD;
                end
                c_CL_SUBU: begin
                    RegDst = 1'b1;
                    ALUctr = c_ALU_SUB;
                end
                c_CL_ORI: begin
                    ExtOp  = c_EXT_ZERO;
                    ALUSrc = 1'b1;
                    ALUctr = c_ALU_OR;
                end
                c_CL_LW: begin
                    ExtOp    = c_EXT_SIGN;
                    ALUSrc   = 1'b1;
                    MemtoReg = 1'b1;
                end
                c_CL_SW: begin
                    ExtOp  = c_EXT_SIGN;
                    ALUSrc = 1'b1;
                end
                c_CL_BEQ: ALUctr = c_ALU_SUB;
                c_CL_LUI: begin
                    ExtOp  = c_EXT_LUI;
                    ALUSrc = 1'b1;
                    ALUctr = c_ALU_OR;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        RegWr      = (r_state == c_ST_WB);
        MemWr      = (r_state == c_ST_MEM) && (w_class == c_CL_SW);
        pc_en      = w_final;
        instr_done = w_final;
        illegal    = (r_state == c_ST_DECODE) && (w_class == c_CL_ILL);
        j_sel      = (r_state == c_ST_DECODE) && (w_class == c_CL_J);
        nPC_sel    = ((r_state == c_ST_EXEC) && (w_class == c_CL_BEQ) && zero)
                     ? 2'b01 : 2'b00;
        jValue     = r_ir[25:0];
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
// ============================================================================
// Module      : tb_mips_mc_ctrl
// Description : Directed-vector bench for mips_mc_ctrl (lui expectations
//               follow MIPS_CTRL_LUI_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instructionOP;
    logic        zero;
    logic        RegDst;
    logic        RegWr;
    logic [1:0]  ExtOp;
    logic [1:0]  ALUctr;
    logic        ALUSrc;
    logic        MemtoReg;
    logic        MemWr;
    logic [1:0]  nPC_sel;
    logic        j_sel;
    logic [25:0] jValue;
    logic        pc_en;
    logic        instr_done;
    logic        illegal;

    int n_vec;
    int n_bad;

    mips_mc_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .instructionOP(instructionOP),
        .zero         (zero),
        .RegDst       (RegDst),
        .RegWr        (RegWr),
        .ExtOp        (ExtOp),
        .ALUctr       (ALUctr),
        .ALUSrc       (ALUSrc),
        .MemtoReg     (MemtoReg),
        .MemWr        (MemWr),
        .nPC_sel      (nPC_sel),
        .j_sel        (j_sel),
        .jValue       (jValue),
        .pc_en        (pc_en),
        .instr_done   (instr_done),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Steering pack: {RegDst, ExtOp, ALUctr, ALUSrc, MemtoReg}
    function automatic logic [6:0] steer_now();
        return {RegDst, ExtOp, ALUctr, ALUSrc, MemtoReg};
    endfunction

    // Strobe pack: {RegWr, MemWr, pc_en, instr_done, illegal, j_sel, nPC_sel}
    function automatic logic [7:0] strobe_now();
        return {RegWr, MemWr, pc_en, instr_done, illegal, j_sel, nPC_sel};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller guarantees the DUT is in FETCH and time is away from a clock edge.
    task automatic run_instr(input string name, input logic [31:0] instr, input logic z,
                             input int ncyc, input logic [6:0] steer,
                             input int regwr_cyc, input int memwr_cyc,
                             input logic [1:0] npc_fin, input logic jsel, input logic ill);
        logic [7:0] exp_st;
        logic       fin;
        instructionOP = instr;
        zero          = z;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            fin    = (c == ncyc);
            exp_st = {(c == regwr_cyc), (c == memwr_cyc), fin, fin, (ill && fin),
                      (jsel && c == 2), (fin ? npc_fin : 2'b00)};
            check($sformatf("%s c%0d steer", name, c), 64'(steer_now()),
                  64'((c == 1) ? 7'd0 : steer));
            check($sformatf("%s c%0d strobe", name, c), 64'(strobe_now()), 64'(exp_st));
            if (c == 2)
                check($sformatf("%s jValue", name), 64'(jValue), 64'(instr[25:0]));
        end
        instructionOP = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec         = 0;
        n_bad         = 0;
        rst           = 1'b0;
        zero          = 1'b1;
        instructionOP = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {23'd0, steer_now(), strobe_now(), jValue}, 64'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;

        run_instr("addu", 32'h0022_1821, 1'b0, 4, 7'b1000000, 4, 0, 2'b00, 1'b0, 1'b0);
        run_instr("subu", 32'h0022_1823, 1'b1, 4, 7'b1000100, 4, 0, 2'b00, 1'b0, 1'b0);
        run_instr("ori",  32'h3422_0005, 1'b1, 4, 7'b0001010, 4, 0, 2'b00, 1'b0, 1'b0);
        run_instr("lw",   32'h8C43_0004, 1'b1, 5, 7'b0010011, 5, 0, 2'b00, 1'b0, 1'b0);
        run_instr("sw",   32'hAC43_0004, 1'b1, 4, 7'b0010010, 0, 4, 2'b00, 1'b0, 1'b0);
        run_instr("beq_t", 32'h1022_0003, 1'b1, 3, 7'b0000100, 0, 0, 2'b01, 1'b0, 1'b0);
        run_instr("beq_n", 32'h1022_0003, 1'b0, 3, 7'b0000100, 0, 0, 2'b00, 1'b0, 1'b0);
        run_instr("j",    32'h0800_0100, 1'b1, 2, 7'b0000000, 0, 0, 2'b00, 1'b1, 1'b0);
        run_instr("ill",  32'hFC00_0000, 1'b1, 2, 7'b0000000, 0, 0, 2'b00, 1'b0, 1'b1);
        run_instr("nop",  32'h0000_0000, 1'b1, 2, 7'b0000000, 0, 0, 2'b00, 1'b0, 1'b1);
        run_instr("badfn", 32'h0022_1820, 1'b1, 2, 7'b0000000, 0, 0, 2'b00, 1'b0, 1'b1);
`ifdef MIPS_CTRL_LUI_EN
        run_instr("lui",  32'h3C01_ABCD, 1'b1, 4, 7'b0101010, 4, 0, 2'b00, 1'b0, 1'b0);
`else
        run_instr("lui",  32'h3C01_ABCD, 1'b1, 2, 7'b0000000, 0, 0, 2'b00, 1'b0, 1'b1);
`endif

        // Abort a lw in MEM with an asynchronous reset between edges.
        instructionOP = 32'h8C43_0004;
        repeat (3) @(posedge clk);
        #1;
        check("lw MEM steer", 64'(steer_now()), 64'(7'b0010011));
        check("lw MEM strobe", 64'(strobe_now()), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check("abort outputs", {23'd0, steer_now(), strobe_now(), jValue}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held reset outputs", {23'd0, steer_now(), strobe_now(), jValue}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        run_instr("addu2", 32'h0022_1821, 1'b1, 4, 7'b1000000, 4, 0, 2'b00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
